// File: rtl/div_unit.sv
// Iterative 32-bit radix-2 restoring divider (DIV/DIVU) for the EX stage; quotient -> LO, remainder -> HI.
// Optional macro DIV_ZERO_FAST_EN: divide-by-zero finishes after one CALC edge instead of 32.
module div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   dq;       // dividend shifts out MSB-first, quotient bits shift in
    logic [WIDTH-1:0]   dvs;
    logic [WIDTH-1:0]   rem;
    logic               sign_q;
    logic               sign_r;
    logic               div0;

    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic               in_div0;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   dq_nxt;

    // Operand magnitudes; a zero divisor keeps the raw dividend so the remainder comes out unmodified
    always_comb begin
        in_div0 = (divisor == '0);
        a_abs   = dividend;
        b_abs   = divisor;
        if (is_signed && dividend[WIDTH-1] && !in_div0) begin
            a_abs = WIDTH'(-dividend);
        end
        if (is_signed && divisor[WIDTH-1]) begin
            b_abs = WIDTH'(-divisor);
        end
    end

    // One restoring shift-subtract step
    always_comb begin
        shifted = {rem, dq[WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
        rem_nxt = shifted[WIDTH-1:0];
        dq_nxt  = {dq[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
            rem_nxt = diff[WIDTH-1:0];
            dq_nxt  = {dq[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            dq        <= '0;
            dvs       <= '0;
            rem       <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            div0      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        dq     <= a_abs;
                        dvs    <= b_abs;
                        rem    <= '0;
                        cnt    <= '0;
                        sign_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        sign_r <= is_signed & dividend[WIDTH-1];
                        div0   <= in_div0;
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
`ifdef DIV_ZERO_FAST_EN
                    else if (div0) begin
                        quotient  <= '1;
                        remainder <= dq;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
`endif
                    else begin
                        dq  <= dq_nxt;
                        rem <= rem_nxt;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            // Zero divisor leaves all-ones quotient and raw dividend; skip sign fix-up
                            quotient  <= (sign_q && !div0) ? WIDTH'(-dq_nxt) : dq_nxt;
                            remainder <= (sign_r && !div0) ? WIDTH'(-rem_nxt) : rem_nxt;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results and completion cycles are queued at issue, checked on done.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] last_q = 32'h0;
    logic [31:0] last_r = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] q, output logic [31:0] r);
        logic signed [31:0] sa;
        logic signed [31:0] sbv;
        sa  = a;
        sbv = b;
        if (b == 32'h0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'h0;
        end else if (s) begin
            q = sa / sbv;
            r = sa % sbv;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic int latency(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        return (b == 32'h0) ? 1 : 32;
`else
        return 32;
`endif
    endfunction

    // Completion monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        start     = 1'b1;
        is_signed = s;
        dividend  = a;
        divisor   = b;
    endtask

    // Called at a negedge: the op is accepted at the next posedge (cyc+1)
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t e;
        ref_div(a, b, s, e.q, e.r);
        e.cyc = cyc + 1 + latency(b);
        sb.push_back(e);
        last_q = e.q;
        last_r = e.r;
        drive_op(a, b, s);
    endtask

    task automatic wait_empty(input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (sb.size() != 0) begin
            check("timeout", 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        issue(a, b, s);
        @(negedge clk);
        start = 1'b0;
        wait_empty(100);
    endtask

    logic [31:0] ta[10] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'h8000_0000,
                            32'd5, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] tb[10] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'd0, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'd0};
    logic        ts[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        flush     = 1'b0;
        is_signed = 1'b0;
        dividend  = 32'h0;
        divisor   = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q", quotient, 32'h0);
        check("rst_r", remainder, 32'h0);
        rst = 1'b0;

        // 100/7 unsigned with busy/done timing around the 32-cycle window
        @(negedge clk);
        issue(32'd100, 32'd7, 1'b0);
        @(negedge clk);
        #1;
        check("busy_first", 32'(busy), 32'd1);
        check("done_first", 32'(done), 32'd0);
        start = 1'b0;
        repeat (31) @(negedge clk);
        #1;
        check("busy_last", 32'(busy), 32'd1);
        check("done_early", 32'(done), 32'd0);
        @(negedge clk);
        #1;
        check("busy_end", 32'(busy), 32'd0);
        check("done_end", 32'(done), 32'd1);
        wait_empty(10);

        // Directed table: signs, overflow, divide-by-zero, extremes
        for (int i = 1; i < 10; i++) run_one(ta[i], tb[i], ts[i]);

        // Random operands with varied divisor magnitudes
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom >> $urandom_range(0, 28);
            if (b == 32'h0) b = 32'd3;
            run_one(a, b, 1'($urandom_range(0, 1)));
        end

        // Flush mid-CALC: no done, outputs hold
        @(negedge clk);
        drive_op(32'd1000, 32'd3, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        flush = 1'b1;
        start = 1'b1;
        @(negedge clk);
        #1;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        check("flush_q", quotient, last_q);
        check("flush_r", remainder, last_r);
        flush = 1'b0;
        start = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        check("flush_busy_later", 32'(busy), 32'd0);
        check("flush_q_later", quotient, last_q);
        check("flush_r_later", remainder, last_r);

        // Async reset mid-CALC
        @(negedge clk);
        drive_op(32'd12345, 32'd11, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_q", quotient, 32'h0);
        check("midrst_r", remainder, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        check("postrst_busy", 32'(busy), 32'd0);

        // Back-to-back with start held: second op accepted two edges after the first done
        @(negedge clk);
        begin
            exp_t e2;
            int   c0;
            c0 = cyc;
            issue(32'd20, 32'd3, 1'b0);
            ref_div(32'd9, 32'd4, 1'b0, e2.q, e2.r);
            e2.cyc = c0 + 1 + 34 + 32;
            sb.push_back(e2);
        end
        @(negedge clk);
        dividend = 32'd9;
        divisor  = 32'd4;
        wait_empty(150);
        start = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
